cam_pattern_gen: RTL

- Synthesisable camera-sensor emulator; sits directly upstream of the dahua_cap capture stage.
- Drives the parallel sensor interface (D_OUT / FV / LV) on pclk with programmable geometry, blanking and test pattern.
- Lets the capture and AXI4-Stream path run on board without a camera, and gives benches a cycle-exact reference source.

---
 rtl/cam_pattern_gen_pkg.sv | 42 ++++
 rtl/cam_pattern_pix.sv | 57 +++++
 rtl/cam_pattern_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cam_pattern_gen_pkg.sv
// Shared definitions for the camera pattern generator and its capture-side
// partner: default frame geometry, FSM state encoding, test pattern encoding,
// and small helpers for sizing counters from geometry parameters.
package cam_pattern_gen_pkg;

  localparam int WIDTH  = 640;  // active pixels per line
  localparam int HEIGTH = 480;  // active lines per frame
  localparam int DATA_W = 8;    // pixel width, matches the capture stage input

  typedef enum logic [2:0] {
    IDLE,
    FRONT,
    LINE,
    HBLK,
    BACK,
    VBLK
  } gen_state_t;

  typedef enum logic [1:0] {
    PAT_RAMP,
    PAT_HCNT,
    PAT_CHECK,
    PAT_FNUM
  } pattern_t;

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max5(input int a, input int b, input int c,
                              input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/cam_pattern_pix.sv
// Pixel value generator for the camera pattern emulator.
// Ports:
//   pclk, reset : pixel clock, synchronous active-high reset
//   lv_i        : line-valid for the pixel being produced (one cycle ahead of LV)
//   pat_i       : latched test pattern for the current frame
//   x_i, y_i    : pixel column / line of the pixel being produced
//   fnum_i      : frame number captured at frame start
//   d_o         : registered pixel data, zero whenever lv_i was low
module cam_pattern_pix
  import cam_pattern_gen_pkg::*;
#(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int PIX_W = 8
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             lv_i,
  input  pattern_t         pat_i,
  input  logic [X_W-1:0]   x_i,
  input  logic [Y_W-1:0]   y_i,
  input  logic [PIX_W-1:0] fnum_i,
  output logic [PIX_W-1:0] d_o
);

  logic [PIX_W-1:0] pix_d;
  logic [PIX_W-1:0] pix_q;
  logic             check_on;

  // 8x8 checker: parity of the tile indices. Widened first so narrow
  // geometries (x or y below 8) simply yield tile 0.
  assign check_on = (((32'(x_i) >> 3) ^ (32'(y_i) >> 3)) & 32'd1) != 32'd0;

  always_comb begin
    pix_d = '0;
    if (lv_i) begin
      case (pat_i)
        PAT_RAMP:  pix_d = PIX_W'(x_i) + PIX_W'(y_i);
        PAT_HCNT:  pix_d = PIX_W'(x_i);
        PAT_CHECK: pix_d = check_on ? '1 : '0;
        PAT_FNUM:  pix_d = fnum_i;
        default:   pix_d = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign d_o = pix_q;

endmodule

// File: rtl/cam_pattern_gen.sv
// Camera sensor emulator: drives a parallel D_OUT/FV/LV interface with
// programmable geometry, blanking and test pattern.
// Ports:
//   pclk, reset  : pixel clock, synchronous active-high reset
//   enable       : run request, only looked at on frame boundaries
//   pattern_sel  : 0 ramp, 1 horizontal counter, 2 8x8 checker, 3 frame number
//   D_OUT        : pixel data, zero while LV is low
//   FV, LV       : frame valid, line valid
//   busy         : high from first FV cycle through last vertical blank cycle
//   frame_cnt    : completed frames, wraps at 16 bits
//
// state | meaning
// IDLE  | stopped, waiting for enable
// FRONT | FV high, vertical front porch
// LINE  | active pixels, LV high
// HBLK  | horizontal blank between lines
// BACK  | FV high, vertical back porch
// VBLK  | FV low, vertical blank between frames
//
// The FSM runs one cycle ahead of the pins; every output is a register
// loaded from the FSM state, so the pins lag the state by exactly one edge.
module cam_pattern_gen #(
  parameter int WIDTH  = cam_pattern_gen_pkg::WIDTH,
  parameter int HEIGTH = cam_pattern_gen_pkg::HEIGTH,
  parameter int DATA_W = cam_pattern_gen_pkg::DATA_W,
  parameter int HBLANK = 16,
  parameter int VFP    = 8,
  parameter int VBP    = 8,
  parameter int VBLANK = 32
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] D_OUT,
  output logic              FV,
  output logic              LV,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  import cam_pattern_gen_pkg::*;

  localparam int X_W   = clog2_min1(WIDTH);
  localparam int Y_W   = clog2_min1(HEIGTH);
  localparam int CNT_W = clog2_min1(max5(WIDTH, HBLANK, VFP, VBP, VBLANK));

  // Phase counter load values: counts down to zero, so load length-1.
  localparam logic [CNT_W-1:0] LD_VFP  = CNT_W'(VFP - 1);
  localparam logic [CNT_W-1:0] LD_LINE = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LD_HBLK = CNT_W'(HBLANK - 1);
  localparam logic [CNT_W-1:0] LD_VBP  = CNT_W'(VBP - 1);
  localparam logic [CNT_W-1:0] LD_VBLK = CNT_W'(VBLANK - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(HEIGTH - 1);

  gen_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  pattern_t          pat_q;
  logic [DATA_W-1:0] fnum_q;
  logic [15:0]       frame_cnt_q;
  logic [15:0]       frame_cnt_out_q;
  logic              fv_q;
  logic              lv_q;
  logic              busy_q;
  logic              line_active;

  assign line_active = (state_q == LINE);

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      x_q             <= '0;
      y_q             <= '0;
      pat_q           <= PAT_RAMP;
      fnum_q          <= '0;
      frame_cnt_q     <= '0;
      frame_cnt_out_q <= '0;
      fv_q            <= 1'b0;
      lv_q            <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // Pin registers follow the state one edge later.
      fv_q            <= (state_q == FRONT) || (state_q == LINE) ||
                         (state_q == HBLK)  || (state_q == BACK);
      lv_q            <= line_active;
      busy_q          <= (state_q != IDLE);
      frame_cnt_out_q <= frame_cnt_q;

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= FRONT;
            cnt_q   <= LD_VFP;
            pat_q   <= pattern_t'(pattern_sel);
            fnum_q  <= DATA_W'(frame_cnt_q);
          end
        end

        FRONT: begin
          if (cnt_q == '0) begin
            state_q <= LINE;
            cnt_q   <= LD_LINE;
            x_q     <= '0;
            y_q     <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        LINE: begin
          if (cnt_q == '0) begin
            x_q <= '0;
            if (y_q == Y_LAST) begin
              state_q <= BACK;
              cnt_q   <= LD_VBP;
            end else begin
              state_q <= HBLK;
              cnt_q   <= LD_HBLK;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            x_q   <= x_q + X_W'(1);
          end
        end

        HBLK: begin
          if (cnt_q == '0) begin
            state_q <= LINE;
            cnt_q   <= LD_LINE;
            y_q     <= y_q + Y_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        BACK: begin
          if (cnt_q == '0) begin
            state_q     <= VBLK;
            cnt_q       <= LD_VBLK;
            y_q         <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        VBLK: begin
          if (cnt_q == '0) begin
            if (enable) begin
              state_q <= FRONT;
              cnt_q   <= LD_VFP;
              pat_q   <= pattern_t'(pattern_sel);
              // frame_cnt_q already counts the frame just finished.
              fnum_q  <= DATA_W'(frame_cnt_q);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Fed from the FSM state so its registered output lines up with lv_q.
  cam_pattern_pix #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .PIX_W (DATA_W)
  ) u_pix (
    .pclk   (pclk),
    .reset  (reset),
    .lv_i   (line_active),
    .pat_i  (pat_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .fnum_i (fnum_q),
    .d_o    (D_OUT)
  );

  assign FV        = fv_q;
  assign LV        = lv_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_out_q;

endmodule
